// File: rtl/temp_sample_proc.sv
// temp_sample_proc: post-processor for ADT7420 temperature readings.
// Converts each {MSB,LSB} register pair into a signed 13-bit sample
// (0.0625 C/LSB) and keeps a power-of-2 moving average, running min/max,
// a saturating sample counter and a hysteresis over-temperature alarm.
//
// Ports:
//   FSM_Clk        sole clock (shared with the I2C read FSM)
//   rst_n          asynchronous active-low reset
//   sample_valid   1-cycle strobe, temp_msb/temp_lsb hold a fresh reading
//   temp_msb/lsb   ADT7420 registers 0x00 / 0x01
//   clear          synchronous clear of statistics (alarm and temp_now kept)
//   hi_thresh      signed alarm threshold, 0.0625 C/LSB
//   temp_now       latest converted sample
//   temp_avg       moving average over 2**AVG_LOG2 samples (0 until window full)
//   avg_valid      averaging window filled since reset/clear
//   temp_min/max   running extremes since reset/clear
//   sample_cnt     accepted samples, saturating at 0xFFFF
//   alarm          over-temperature alarm with HYST LSBs of hysteresis
//   overrun        sticky: a strobe arrived while a sample was in flight
//   out_valid      1-cycle pulse, all outputs reflect the latest sample
module temp_sample_proc #(
    parameter int unsigned AVG_LOG2 = 2,
    parameter int unsigned HYST     = 16
) (
    input  logic               FSM_Clk,
    input  logic               rst_n,
    input  logic               sample_valid,
    input  logic [7:0]         temp_msb,
    input  logic [7:0]         temp_lsb,
    input  logic               clear,
    input  logic signed [12:0] hi_thresh,
    output logic signed [12:0] temp_now,
    output logic signed [12:0] temp_avg,
    output logic               avg_valid,
    output logic signed [12:0] temp_min,
    output logic signed [12:0] temp_max,
    output logic [15:0]        sample_cnt,
    output logic               alarm,
    output logic               overrun,
    output logic               out_valid
);

    localparam int unsigned TW     = 13;
    localparam int unsigned DEPTH  = 1 << AVG_LOG2;
    localparam int unsigned SUM_W  = TW + AVG_LOG2;
    localparam int unsigned FILL_W = AVG_LOG2 + 1;
    localparam int unsigned CNT_W  = 16;
    localparam int unsigned CMP_W  = TW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_ACC  = 2'd2,
        S_OUT  = 2'd3
    } state_e;

    state_e state_q, state_d;

    logic signed [TW-1:0]    samp_q, samp_d;
    logic signed [TW-1:0]    temp_now_q, temp_now_d;
    logic signed [TW-1:0]    ring_q [DEPTH];
    logic signed [TW-1:0]    ring_d [DEPTH];
    logic signed [SUM_W-1:0] sum_q, sum_d;
    logic [AVG_LOG2-1:0]     wp_q, wp_d;
    logic [FILL_W-1:0]       fill_q, fill_d;
    logic signed [TW-1:0]    min_q, min_d;
    logic signed [TW-1:0]    max_q, max_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic signed [TW-1:0]    avg_q, avg_d;
    logic                    avg_valid_q, avg_valid_d;
    logic                    alarm_q, alarm_d;
    logic                    overrun_q, overrun_d;
    logic                    out_valid_q, out_valid_d;
    logic                    clr_pend_q, clr_pend_d;

    logic                    acc_clr_c;
    logic                    do_clr_c;
    logic signed [CMP_W-1:0] thr_lo_c;
    logic signed [CMP_W-1:0] samp_ext_c;
    logic                    unused_lsb_c;

    // The three LSBs of the LSB register are status flags, not temperature.
    assign unused_lsb_c = ^temp_lsb[2:0];

    // A clear seen in CONV/ACC is applied as the in-flight sample finishes
    // (stats read as cleared when out_valid pulses); in IDLE/OUT it is immediate.
    assign acc_clr_c = (state_q == S_ACC) && (clr_pend_q || clear);
    assign do_clr_c  = acc_clr_c || (clear && ((state_q == S_IDLE) || (state_q == S_OUT)));

    // Lower alarm threshold, widened so hi_thresh - HYST cannot wrap.
    assign thr_lo_c   = CMP_W'(hi_thresh) - CMP_W'(HYST);
    assign samp_ext_c = CMP_W'(samp_q);

    // Next-state logic for the processing sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (sample_valid) state_d = S_CONV;
            S_CONV:  state_d = S_ACC;
            S_ACC:   state_d = S_OUT;
            S_OUT:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath next-state: outputs are computed at the ACC->OUT edge so
    // they are all valid during the OUT cycle alongside out_valid.
    always_comb begin
        samp_d      = samp_q;
        temp_now_d  = temp_now_q;
        ring_d      = ring_q;
        sum_d       = sum_q;
        wp_d        = wp_q;
        fill_d      = fill_q;
        min_d       = min_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        avg_d       = avg_q;
        avg_valid_d = avg_valid_q;
        alarm_d     = alarm_q;
        overrun_d   = overrun_q;
        clr_pend_d  = clr_pend_q;
        out_valid_d = 1'b0;

        if ((state_q == S_IDLE) && sample_valid) begin
            samp_d = {temp_msb, temp_lsb[7:3]};
        end

        if (state_q == S_CONV) begin
            temp_now_d = samp_q;
            if (clear) clr_pend_d = 1'b1;
        end

        if ((state_q != S_IDLE) && sample_valid) begin
            overrun_d = 1'b1;
        end

        if (state_q == S_ACC) begin
            out_valid_d = 1'b1;
            clr_pend_d  = 1'b0;

            if (samp_q >= hi_thresh) begin
                alarm_d = 1'b1;
            end else if (samp_ext_c < thr_lo_c) begin
                alarm_d = 1'b0;
            end

            if (!acc_clr_c) begin
                // Running sum always holds exactly the ring contents.
                sum_d         = sum_q + SUM_W'(samp_q) - SUM_W'(ring_q[wp_q]);
                ring_d[wp_q]  = samp_q;
                wp_d          = wp_q + AVG_LOG2'(1);
                if (fill_q != FILL_W'(DEPTH)) fill_d = fill_q + FILL_W'(1);

                if (fill_q == '0) begin
                    min_d = samp_q;
                    max_d = samp_q;
                end else begin
                    if (samp_q < min_q) min_d = samp_q;
                    if (samp_q > max_q) max_d = samp_q;
                end

                if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);

                if (fill_d == FILL_W'(DEPTH)) begin
                    avg_d       = TW'(sum_d >>> AVG_LOG2);
                    avg_valid_d = 1'b1;
                end
            end
        end

        if (do_clr_c) begin
            for (int i = 0; i < int'(DEPTH); i++) ring_d[i] = '0;
            sum_d       = '0;
            wp_d        = '0;
            fill_d      = '0;
            min_d       = '0;
            max_d       = '0;
            cnt_d       = '0;
            avg_d       = '0;
            avg_valid_d = 1'b0;
            overrun_d   = 1'b0;
            clr_pend_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge FSM_Clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            samp_q      <= '0;
            temp_now_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) ring_q[i] <= '0;
            sum_q       <= '0;
            wp_q        <= '0;
            fill_q      <= '0;
            min_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
            alarm_q     <= 1'b0;
            overrun_q   <= 1'b0;
            out_valid_q <= 1'b0;
            clr_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            samp_q      <= samp_d;
            temp_now_q  <= temp_now_d;
            ring_q      <= ring_d;
            sum_q       <= sum_d;
            wp_q        <= wp_d;
            fill_q      <= fill_d;
            min_q       <= min_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
            alarm_q     <= alarm_d;
            overrun_q   <= overrun_d;
            out_valid_q <= out_valid_d;
            clr_pend_q  <= clr_pend_d;
        end
    end

    assign temp_now   = temp_now_q;
    assign temp_avg   = avg_q;
    assign avg_valid  = avg_valid_q;
    assign temp_min   = min_q;
    assign temp_max   = max_q;
    assign sample_cnt = cnt_q;
    assign alarm      = alarm_q;
    assign overrun    = overrun_q;
    assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_temp_sample_proc.sv
// tb_temp_sample_proc: directed bench for temp_sample_proc with
// hand-computed expected values.
module tb_temp_sample_proc;

    logic               FSM_Clk = 1'b0;
    logic               rst_n;
    logic               sample_valid;
    logic [7:0]         temp_msb;
    logic [7:0]         temp_lsb;
    logic               clear;
    logic signed [12:0] hi_thresh;
    logic signed [12:0] temp_now;
    logic signed [12:0] temp_avg;
    logic               avg_valid;
    logic signed [12:0] temp_min;
    logic signed [12:0] temp_max;
    logic [15:0]        sample_cnt;
    logic               alarm;
    logic               overrun;
    logic               out_valid;

    int n_checks = 0;
    int n_errors = 0;

    always #5 FSM_Clk = ~FSM_Clk;

    temp_sample_proc #(.AVG_LOG2(2), .HYST(16)) dut (
        .FSM_Clk      (FSM_Clk),
        .rst_n        (rst_n),
        .sample_valid (sample_valid),
        .temp_msb     (temp_msb),
        .temp_lsb     (temp_lsb),
        .clear        (clear),
        .hi_thresh    (hi_thresh),
        .temp_now     (temp_now),
        .temp_avg     (temp_avg),
        .avg_valid    (avg_valid),
        .temp_min     (temp_min),
        .temp_max     (temp_max),
        .sample_cnt   (sample_cnt),
        .alarm        (alarm),
        .overrun      (overrun),
        .out_valid    (out_valid)
    );

    // Compare one observed value against its expected value.
    task automatic check(input string tag, input logic signed [31:0] got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge FSM_Clk);
        #1;
    endtask

    // Strobe one reading and return during its OUT cycle, checking latency.
    task automatic send(input logic [7:0] msb, input logic [7:0] lsb, input string tag);
        cyc();
        sample_valid = 1'b1;
        temp_msb     = msb;
        temp_lsb     = lsb;
        cyc();
        sample_valid = 1'b0;
        cyc();
        check({tag, "_ov_early"}, out_valid, 0);
        cyc();
        check({tag, "_ov"}, out_valid, 1);
    endtask

    task automatic pulse_clear();
        cyc();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_now"},   temp_now, 0);
        check({tag, "_avg"},   temp_avg, 0);
        check({tag, "_avgv"},  avg_valid, 0);
        check({tag, "_min"},   temp_min, 0);
        check({tag, "_max"},   temp_max, 0);
        check({tag, "_cnt"},   sample_cnt, 0);
        check({tag, "_alarm"}, alarm, 0);
        check({tag, "_ovr"},   overrun, 0);
        check({tag, "_ov"},    out_valid, 0);
    endtask

    initial begin
        rst_n        = 1'b0;
        sample_valid = 1'b0;
        temp_msb     = 8'h00;
        temp_lsb     = 8'h00;
        clear        = 1'b0;
        hi_thresh    = 13'sd480;

        repeat (3) cyc();
        check_all_zero("rst");
        rst_n = 1'b1;

        // 25.0 C
        send(8'h0C, 8'h80, "t1");
        check("t1_now", temp_now, 400);
        check("t1_min", temp_min, 400);
        check("t1_max", temp_max, 400);
        check("t1_cnt", sample_cnt, 1);
        check("t1_avgv", avg_valid, 0);
        cyc();
        check("t1_ov_after", out_valid, 0);

        // -50.0 C
        send(8'hE7, 8'h00, "t2");
        check("t2_now", temp_now, -800);
        check("t2_min", temp_min, -800);
        check("t2_max", temp_max, 400);
        check("t2_cnt", sample_cnt, 2);

        pulse_clear();
        check("clr_cnt", sample_cnt, 0);
        check("clr_min", temp_min, 0);
        check("clr_max", temp_max, 0);
        check("clr_now_held", temp_now, -800);

        // Moving average over 4 samples
        send(8'h0C, 8'h80, "t3a");
        send(8'h0C, 8'h80, "t3b");
        send(8'h0C, 8'h80, "t3c");
        check("t3c_avgv", avg_valid, 0);
        check("t3c_avg", temp_avg, 0);
        send(8'h19, 8'h00, "t3d");
        check("t3d_avgv", avg_valid, 1);
        check("t3d_avg", temp_avg, 500);
        check("t3d_alarm", alarm, 1);
        send(8'h19, 8'h00, "t3e");
        check("t3e_avg", temp_avg, 600);
        check("t3e_min", temp_min, 400);
        check("t3e_max", temp_max, 800);
        check("t3e_cnt", sample_cnt, 5);

        // Alarm hysteresis around 480 / 464
        send(8'h0C, 8'h80, "t4a");
        check("t4a_alarm", alarm, 0);
        send(8'h0F, 8'h00, "t4b");
        check("t4b_alarm", alarm, 1);
        send(8'h0E, 8'hB0, "t4c");
        check("t4c_now", temp_now, 470);
        check("t4c_alarm", alarm, 1);
        send(8'h0E, 8'h80, "t4d");
        check("t4d_alarm", alarm, 1);
        send(8'h0E, 8'h78, "t4e");
        check("t4e_now", temp_now, 463);
        check("t4e_alarm", alarm, 0);

        // Overrun: second strobe two cycles after the first
        pulse_clear();
        cyc();
        sample_valid = 1'b1;
        temp_msb     = 8'h0C;
        temp_lsb     = 8'h80;
        cyc();
        sample_valid = 1'b0;
        cyc();
        sample_valid = 1'b1;
        temp_msb     = 8'h19;
        temp_lsb     = 8'h00;
        cyc();
        sample_valid = 1'b0;
        check("t5_ov", out_valid, 1);
        check("t5_ovr", overrun, 1);
        check("t5_cnt", sample_cnt, 1);
        repeat (4) begin
            cyc();
            check("t5_no_ov", out_valid, 0);
        end
        check("t5_cnt_hold", sample_cnt, 1);
        check("t5_max", temp_max, 400);
        pulse_clear();
        check("t5_clr_ovr", overrun, 0);
        check("t5_clr_cnt", sample_cnt, 0);

        // Clear while busy: sample completes, stats read as cleared
        send(8'h0F, 8'h00, "tb0");
        cyc();
        sample_valid = 1'b1;
        temp_msb     = 8'h0C;
        temp_lsb     = 8'h80;
        cyc();
        sample_valid = 1'b0;
        clear        = 1'b1;
        cyc();
        clear = 1'b0;
        cyc();
        check("tb_ov", out_valid, 1);
        check("tb_now", temp_now, 400);
        check("tb_cnt", sample_cnt, 0);
        check("tb_max", temp_max, 0);

        // Clear and strobe together in IDLE
        send(8'h0C, 8'h80, "tc0");
        cyc();
        clear        = 1'b1;
        sample_valid = 1'b1;
        temp_msb     = 8'h0F;
        temp_lsb     = 8'h00;
        cyc();
        clear        = 1'b0;
        sample_valid = 1'b0;
        cyc();
        cyc();
        check("tc_ov", out_valid, 1);
        check("tc_cnt", sample_cnt, 1);
        check("tc_min", temp_min, 480);
        check("tc_max", temp_max, 480);

        // Reset asserted while in ACC
        cyc();
        sample_valid = 1'b1;
        temp_msb     = 8'h0C;
        temp_lsb     = 8'h80;
        cyc();
        sample_valid = 1'b0;
        cyc();
        rst_n = 1'b0;
        #1;
        check_all_zero("t6_rst");
        cyc();
        check("t6_no_ov", out_valid, 0);
        rst_n = 1'b1;
        send(8'h10, 8'h00, "t6s");
        check("t6_cnt", sample_cnt, 1);
        check("t6_min", temp_min, 512);
        check("t6_max", temp_max, 512);
        check("t6_alarm", alarm, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
